// File: rtl/ict106_axilite_regs.sv
// AXI4-Lite responder register bank: NUM_REGS byte-strobed RW control words followed
// by NUM_REGS read-only status words, decoded from address bits [9:2].
module ict106_axilite_regs #(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS         = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]        reg_out,
  output logic [NUM_REGS-1:0]           reg_wr_pulse,
  input  logic [NUM_REGS*32-1:0]        status_in
);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  function automatic resp_e decode_resp(input logic [7:0] idx, input logic is_write);
    if (int'(idx) < NUM_REGS)        return RESP_OKAY;
    else if (int'(idx) < 2*NUM_REGS) return is_write ? RESP_SLVERR : RESP_OKAY;
    else                             return RESP_DECERR;
  endfunction

  logic                          r_init;
  logic                          r_aw_held;
  logic [7:0]                    r_aw_idx;
  logic                          r_w_held;
  logic [C_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [C_AXI_DATA_WIDTH/8-1:0] r_wstrb;
  logic                          r_bvalid;
  resp_e                         r_bresp;
  logic                          r_rvalid;
  logic [C_AXI_DATA_WIDTH-1:0]   r_rdata;
  resp_e                         r_rresp;
  logic [NUM_REGS-1:0]           r_wr_pulse;
  logic [31:0]                   r_regs [NUM_REGS];

  logic                          w_awready;
  logic                          w_wready;
  logic                          w_arready;
  logic                          w_commit;
  logic [7:0]                    w_ar_idx;
  logic [C_AXI_DATA_WIDTH-1:0]   w_rd_data;
  logic                          w_unused;

  // r_init keeps every ready low until the first edge after reset release.
  assign w_awready = r_init & ~r_aw_held & ~r_bvalid;
  assign w_wready  = r_init & ~r_w_held  & ~r_bvalid;
  assign w_arready = r_init & ~r_rvalid;
  assign w_commit  = r_aw_held & r_w_held;
  assign w_ar_idx  = S_AXI_ARADDR[9:2];
  assign w_unused  = ^{S_AXI_AWADDR[C_AXI_ADDR_WIDTH-1:10], S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[C_AXI_ADDR_WIDTH-1:10], S_AXI_ARADDR[1:0]};

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == 8'(i))            w_rd_data = r_regs[i];
      if (w_ar_idx == 8'(NUM_REGS + i)) w_rd_data = status_in[32*i +: 32];
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[32*i +: 32] = r_regs[i];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_init     <= 1'b0;
      r_aw_held  <= 1'b0;
      r_aw_idx   <= '0;
      r_w_held   <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
      // NOTE: the register array is reset because downstream configuration must start from zero.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_init     <= 1'b1;
      r_wr_pulse <= '0;

      if (S_AXI_AWVALID && w_awready) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= S_AXI_AWADDR[9:2];
      end
      if (S_AXI_WVALID && w_wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end

      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= decode_resp(r_aw_idx, 1'b1);
        for (int i = 0; i < NUM_REGS; i++) begin
          if (r_aw_idx == 8'(i)) begin
            r_wr_pulse[i] <= 1'b1;
            for (int b = 0; b < 4; b++)
              if (r_wstrb[b]) r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
        r_bresp  <= RESP_OKAY;
      end

      // Reads sample r_regs before any same-edge commit, returning the pre-write value.
      if (S_AXI_ARVALID && w_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= decode_resp(w_ar_idx, 1'b0);
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
        r_rresp  <= RESP_OKAY;
      end
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign reg_wr_pulse  = r_wr_pulse;

endmodule

// File: tb/tb_ict106_axilite_regs.sv
// Self-checking bench for ict106_axilite_regs: directed protocol steps followed by
// randomized reads/writes scored against an array model of the register map.
module tb_ict106_axilite_regs;

  localparam int NR = 8;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [31:0]   S_AXI_AWADDR;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [31:0]   S_AXI_ARADDR;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;
  logic [NR*32-1:0] reg_out;
  logic [NR-1:0]    reg_wr_pulse;
  logic [NR*32-1:0] status;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [NR];

  ict106_axilite_regs #(.C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse), .status_in(status)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Reference model: register map behaviour from the address rules, in plain arithmetic.
  function automatic logic [1:0] exp_resp(input int idx, input bit is_wr);
    if (idx < NR)   return 2'b00;
    if (idx < 2*NR) return is_wr ? 2'b10 : 2'b00;
    return 2'b11;
  endfunction

  function automatic logic [31:0] exp_rdata(input int idx);
    if (idx < NR)   return model[idx];
    if (idx < 2*NR) return status[32*(idx-NR) +: 32];
    return 32'h0;
  endfunction

  function automatic logic [255:0] model_vec();
    logic [255:0] v = '0;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    if (idx < NR)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly,
                          output logic [1:0] resp, output logic [7:0] pulse);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_hs, w_hs;
    int cyc = 0;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      #0;
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      step();
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    cyc = 0;
    while (!S_AXI_BVALID && cyc < 50) begin
      step();
      cyc++;
    end
    check("write_bvalid_timeout", S_AXI_BVALID, 1'b1);
    resp  = S_AXI_BRESP;
    pulse = reg_wr_pulse;
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cyc = 0;
    bit hs = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!hs && cyc < 50) begin
      #0;
      hs = S_AXI_ARREADY;
      step();
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    cyc = 0;
    while (!S_AXI_RVALID && cyc < 50) begin
      step();
      cyc++;
    end
    check("read_rvalid_timeout", S_AXI_RVALID, 1'b1);
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    step();
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [7:0]  pulse;
    logic [31:0] rdata;
    logic [31:0] tmp;
    int          idx;
    int          nval;

    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0;  S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    status = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state and the one-cycle delayed ready release.
    #22;
    check("rst_awready", S_AXI_AWREADY, 1'b0);
    check("rst_arready", S_AXI_ARREADY, 1'b0);
    check("rst_reg_out", reg_out, '0);
    ARESETN = 1'b1;
    check("rel_awready_before_edge", S_AXI_AWREADY, 1'b0);
    step();
    check("rel_awready", S_AXI_AWREADY, 1'b1);
    check("rel_wready", S_AXI_WREADY, 1'b1);
    check("rel_arready", S_AXI_ARREADY, 1'b1);
    check("rel_bvalid", S_AXI_BVALID, 1'b0);
    check("rel_rvalid", S_AXI_RVALID, 1'b0);

    // AW first, W three cycles later.
    S_AXI_AWADDR = 32'h004; S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    check("aw_first_awready", S_AXI_AWREADY, 1'b0);
    check("aw_first_wready", S_AXI_WREADY, 1'b1);
    step(); step();
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_WVALID = 1'b0;
    check("aw_first_no_early_b", S_AXI_BVALID, 1'b0);
    step();
    model_write(1, 32'hDEADBEEF, 4'hF);
    check("aw_first_bvalid", S_AXI_BVALID, 1'b1);
    check("aw_first_bresp", S_AXI_BRESP, 2'b00);
    check("aw_first_reg_out", reg_out, model_vec());
    check("aw_first_pulse", reg_wr_pulse, 8'h02);
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
    check("aw_first_pulse_gone", reg_wr_pulse, 8'h00);
    check("aw_first_bvalid_clr", S_AXI_BVALID, 1'b0);
    check("aw_first_awready_back", S_AXI_AWREADY, 1'b1);

    // W first, then AW; response back-pressured for five cycles.
    S_AXI_WDATA = 32'h000000AA; S_AXI_WSTRB = 4'h1; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_WVALID = 1'b0;
    S_AXI_AWADDR = 32'h004; S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    step();
    model_write(1, 32'h000000AA, 4'h1);
    check("w_first_reg_out", reg_out, model_vec());
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", S_AXI_BVALID, 1'b1);
      check("bp_awready", S_AXI_AWREADY, 1'b0);
      check("bp_wready", S_AXI_WREADY, 1'b0);
      step();
    end
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
    check("bp_released", S_AXI_BVALID, 1'b0);

    // Read-only status word and its write rejection.
    status[32*2 +: 32] = 32'h12345678;
    do_read(32'h028, rdata, resp);
    check("ro_rdata", rdata, 32'h12345678);
    check("ro_rresp", resp, 2'b00);
    do_write(32'h028, 32'hFFFFFFFF, 4'hF, 0, 0, resp, pulse);
    check("ro_wr_bresp", resp, 2'b10);
    check("ro_wr_pulse", pulse, 8'h00);
    check("ro_wr_reg_out", reg_out, model_vec());

    // Unmapped accesses and address aliasing.
    do_read(32'h100, rdata, resp);
    check("unmap_rdata", rdata, 32'h0);
    check("unmap_rresp", resp, 2'b11);
    do_write(32'h3FC, 32'h55555555, 4'hF, 0, 0, resp, pulse);
    check("unmap_bresp", resp, 2'b11);
    check("unmap_reg_out", reg_out, model_vec());
    do_read(32'h404, rdata, resp);
    check("alias_rdata", rdata, 32'hDEADBEAA);
    check("alias_rresp", resp, 2'b00);

    // AW+W together, then a read accepted on the commit edge sees the old value.
    S_AXI_AWADDR = 32'h000; S_AXI_WDATA = 32'h11223344; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("both_held_awready", S_AXI_AWREADY, 1'b0);
    check("both_held_wready", S_AXI_WREADY, 1'b0);
    S_AXI_ARADDR = 32'h000; S_AXI_ARVALID = 1'b1;
    step();
    S_AXI_ARVALID = 1'b0;
    check("same_edge_rvalid", S_AXI_RVALID, 1'b1);
    check("same_edge_old_value", S_AXI_RDATA, model[0]);
    check("same_edge_bvalid", S_AXI_BVALID, 1'b1);
    model_write(0, 32'h11223344, 4'hF);
    check("same_edge_reg_out", reg_out, model_vec());
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    step();
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;

    // Back-to-back reads: at most one every two cycles.
    S_AXI_ARADDR = 32'h004; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    nval = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (S_AXI_RVALID) nval++;
    end
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    check("read_throughput", nval, 3);
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NR; i++) status[32*i +: 32] = $urandom();
      case ($urandom_range(0, 2))
        0:       idx = $urandom_range(0, NR-1);
        1:       idx = $urandom_range(NR, 2*NR-1);
        default: idx = $urandom_range(2*NR, 255);
      endcase
      tmp = $urandom();
      tmp[9:2] = 8'(idx);
      if ($urandom_range(0, 1) == 0) begin
        logic [31:0] wd;
        logic [3:0]  ws;
        wd = $urandom();
        ws = 4'($urandom_range(0, 15));
        do_write(tmp, wd, ws, $urandom_range(0, 2), $urandom_range(0, 2), resp, pulse);
        model_write(idx, wd, ws);
        check("rnd_bresp", resp, exp_resp(idx, 1'b1));
        check("rnd_pulse", pulse, (idx < NR) ? 8'(1 << idx) : 8'h00);
        check("rnd_reg_out", reg_out, model_vec());
      end else begin
        do_read(tmp, rdata, resp);
        check("rnd_rdata", rdata, exp_rdata(idx));
        check("rnd_rresp", resp, exp_resp(idx, 1'b0));
      end
    end

    // Reset while a read response and a lone AW are pending.
    S_AXI_ARADDR = 32'h004; S_AXI_ARVALID = 1'b1;
    step();
    S_AXI_ARVALID = 1'b0;
    S_AXI_AWADDR = 32'h008; S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    check("pre_rst_rvalid", S_AXI_RVALID, 1'b1);
    #2;
    ARESETN = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    check("mid_rst_rvalid", S_AXI_RVALID, 1'b0);
    check("mid_rst_awready", S_AXI_AWREADY, 1'b0);
    check("mid_rst_reg_out", reg_out, model_vec());
    step(); step();
    ARESETN = 1'b1;
    step();
    check("post_rst_awready", S_AXI_AWREADY, 1'b1);
    S_AXI_WDATA = 32'h00000055; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_WVALID = 1'b0;
    step(); step(); step();
    check("stale_aw_no_b", S_AXI_BVALID, 1'b0);
    check("stale_aw_reg_out", reg_out, model_vec());
    S_AXI_AWADDR = 32'h008; S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    step();
    model_write(2, 32'h00000055, 4'hF);
    check("post_rst_bvalid", S_AXI_BVALID, 1'b1);
    check("post_rst_bresp", S_AXI_BRESP, 2'b00);
    check("post_rst_reg_out", reg_out, model_vec());
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
